instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage directly downstream of the PC register. Captures the current PC, performs a variable-latency req/ack read of instruction memory, and holds the returned word in an instruction register for decode under a valid/ready handshake. Drives `PCWre` so the PC advances exactly once per accepted instruction. Supports branch-redirect flush and traps misaligned PCs.

## Interface
- `ADDR_W`, 32: PC / memory address width.
- `DATA_W`, 32: instruction width.
- `CNT_W`, 32: fetch counter width.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `PCout`  in  ADDR_W  current PC from the PC register.
- `PCWre`  out  1  PC write enable to the PC register (combinational, Mealy).
- `flush`  in  1  branch redirect; the PC is reloaded externally at this edge.
- `imem_req`  out  1  memory request.
- `imem_addr`  out  ADDR_W  request address, registered.
- `imem_ack`  in  1  memory acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  DATA_W  instruction word.
- `ir_valid`  out  1  instruction register holds a valid instruction.
- `ir_ready`  in  1  decode accepts the instruction.
- `ir`  out  DATA_W  instruction register.
- `ir_pc`  out  ADDR_W  address of the instruction in `ir`.
- `fetch_count`  out  CNT_W  number of instructions accepted into `ir`; wraps modulo 2^CNT_W.
- `align_err`  out  1  sticky misaligned-PC fault.

## Operation
- States: IDLE, REQ, HOLD, DROP, FAULT.
- IDLE: go to REQ and capture `imem_addr <= PCout`. If `PCout[1:0] != 0`, go to FAULT and set `align_err`.
- REQ: `imem_req=1`, `imem_addr` stable.
  - `imem_ack & !flush`: load `ir <= imem_rdata` and `ir_pc <= imem_addr`, increment `fetch_count`, assert `PCWre` this cycle, then go to HOLD.
  - `imem_ack & flush`: discard the data, go to IDLE.
  - `!imem_ack & flush`: go to DROP.
- HOLD: `ir_valid=1`.
  - `flush`: go to IDLE; `ir_valid` falls.
  - `ir_ready & !flush`: go to REQ, capturing `PCout`, with the same alignment check as IDLE.
  - Neither: stay in HOLD; `ir` and `ir_pc` stay stable.
- DROP: `imem_req=1` with the old address until `imem_ack`, then go to IDLE. Further `flush` pulses keep DROP. Nothing is loaded and `PCWre` stays 0.
- FAULT: all outputs idle, `align_err=1`. Exit is by Reset only.
- `PCWre = (state==REQ) & imem_ack & !flush`. It is never asserted in any other state.
- `imem_req = (state==REQ) | (state==DROP)`.
- `flush` takes priority over `ir_ready` and over `imem_ack` data.

## Timing
- Reset values: state=IDLE, `imem_req=0`, `imem_addr=0`, `ir=0`, `ir_pc=0`, `ir_valid=0`, `fetch_count=0`, `align_err=0`, `PCWre=0`.
- Reset asserted mid-transaction abandons the request immediately. The memory must tolerate `imem_req` dropping before `imem_ack`.
- Zero-wait memory (ack in the first REQ cycle): REQ→HOLD in 1 cycle.
- Best-case throughput is 1 instruction per 2 cycles (REQ, HOLD with `ir_ready`).
- First request is issued in cycle 1 after reset release (the IDLE cycle comes first).
- The PC updates at the same edge that loads `ir`. The next REQ therefore captures PC+4.
- After `flush`, the first request uses the redirected PC, one IDLE cycle later.
- `imem_addr` never changes while `imem_req=1`.

## Structure
- `fetch_pkg` holds the state enum (`FS_IDLE`, `FS_REQ`, `FS_HOLD`, `FS_DROP`, `FS_FAULT`) and the alignment-mask constant.
- Single module with no sub-modules. The next-state and `PCWre` logic are combinational; registers use async reset.

## Test plan
- Reset release, zero-wait memory, PC starts at 0x0, `ir_ready=1`, memory returns 0xAAAA0000+addr → `imem_addr` sequence 0x0, 0x4, 0x8. One `PCWre` pulse per word. `ir_pc` matches the address. `fetch_count` reaches 3 after 3 fetches.
- Ack delayed 3 cycles → `imem_req` held 4 cycles with constant address. Exactly one `PCWre`.
- `ir_ready=0` for 5 cycles in HOLD → `ir`, `ir_pc` stable. No new request. `PCWre=0`.
- `flush` in REQ before ack, PC redirected to 0x100 → DROP until ack. No load and no `PCWre`. Next request uses address 0x100.
- `flush` coinciding with ack → data discarded, `fetch_count` unchanged, next address is the redirected PC.
- PC presented as 0x102 → FAULT with `align_err=1` and no further requests. Reset clears the fault.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_HOLD  = 3'd2,
        FS_DROP  = 3'd3,
        FS_FAULT = 3'd4
    } fetch_state_t;

    // Instructions are word aligned, so the two low PC bits must be zero.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] pc_lsb);
        return ((pc_lsb & ALIGN_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Signal bundle between the fetch stage and its PC register, memory and decode.
interface instruction_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) ();

    logic [ADDR_W-1:0] PCout;
    logic              PCWre;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic [CNT_W-1:0]  fetch_count;
    logic              align_err;

    modport master (
        input  PCout, flush, imem_ack, imem_rdata, ir_ready,
        output PCWre, imem_req, imem_addr, ir_valid, ir, ir_pc,
               fetch_count, align_err
    );

    modport slave (
        output PCout, flush, imem_ack, imem_rdata, ir_ready,
        input  PCWre, imem_req, imem_addr, ir_valid, ir, ir_pc,
               fetch_count, align_err
    );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: captures the PC, reads instruction memory over req/ack and
// holds the word for decode; advances the PC once per accepted instruction.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                 CLK,
    input  logic                 Reset,
    instruction_fetch_if.master  bus
);

    fetch_state_t      state_r;
    fetch_state_t      state_nxt_s;
    logic              capture_s;
    logic              load_s;
    logic              fault_s;
    logic              pc_ok_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] ir_r;
    logic [ADDR_W-1:0] ir_pc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              align_r;

    assign pc_ok_s = is_aligned(bus.PCout[1:0]);

    // Next-state selection; flush outranks both returned data and ir_ready.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        load_s      = 1'b0;
        fault_s     = 1'b0;
        case (state_r)
            FS_IDLE: begin
                if (pc_ok_s) begin
                    state_nxt_s = FS_REQ;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = FS_FAULT;
                    fault_s     = 1'b1;
                end
            end
            FS_REQ: begin
                if (bus.imem_ack && !bus.flush) begin
                    state_nxt_s = FS_HOLD;
                    load_s      = 1'b1;
                end else if (bus.imem_ack) begin
                    state_nxt_s = FS_IDLE;
                end else if (bus.flush) begin
                    state_nxt_s = FS_DROP;
                end else begin
                    state_nxt_s = FS_REQ;
                end
            end
            FS_HOLD: begin
                if (bus.flush) begin
                    state_nxt_s = FS_IDLE;
                end else if (bus.ir_ready) begin
                    if (pc_ok_s) begin
                        state_nxt_s = FS_REQ;
                        capture_s   = 1'b1;
                    end else begin
                        state_nxt_s = FS_FAULT;
                        fault_s     = 1'b1;
                    end
                end else begin
                    state_nxt_s = FS_HOLD;
                end
            end
            FS_DROP: begin
                // A request already on the bus must complete before a new one.
                if (bus.imem_ack) begin
                    state_nxt_s = FS_IDLE;
                end else begin
                    state_nxt_s = FS_DROP;
                end
            end
            FS_FAULT: begin
                state_nxt_s = FS_FAULT;
            end
            default: begin
                state_nxt_s = FS_IDLE;
            end
        endcase
    end

    // State, request address, instruction register, counter and fault flag.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r <= FS_IDLE;
            addr_r  <= '0;
            ir_r    <= '0;
            ir_pc_r <= '0;
            cnt_r   <= '0;
            align_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                addr_r <= bus.PCout;
            end
            if (load_s) begin
                ir_r    <= bus.imem_rdata;
                ir_pc_r <= addr_r;
                cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (fault_s) begin
                align_r <= 1'b1;
            end
        end
    end

    // The PC register advances on the same edge that loads ir.
    assign bus.PCWre       = load_s;
    assign bus.imem_req    = (state_r == FS_REQ) || (state_r == FS_DROP);
    assign bus.imem_addr   = addr_r;
    assign bus.ir_valid    = (state_r == FS_HOLD);
    assign bus.ir          = ir_r;
    assign bus.ir_pc       = ir_pc_r;
    assign bus.fetch_count = cnt_r;
    assign bus.align_err   = align_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC register, a variable-latency
// memory and a transaction-level expectation model checked every cycle.
module tb_instruction_fetch;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] pc;
    logic [31:0] redirect = 32'h0;
    logic        flush = 1'b0;
    logic        ir_ready = 1'b0;
    int          mem_lat = 0;
    int          mem_cnt;
    int          checks = 0;
    int          errors = 0;
    int          pcwre_n = 0;
    int          req_n = 0;
    logic [31:0] addr_log[$];

    always #5 CLK = ~CLK;

    instruction_fetch_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.PCout      = pc;
    assign bus.flush      = flush;
    assign bus.ir_ready   = ir_ready;
    assign bus.imem_ack   = bus.imem_req && (mem_cnt == mem_lat);
    assign bus.imem_rdata = 32'hAAAA_0000 + bus.imem_addr;

    // PC register: redirect on flush, otherwise +4 on PCWre
    always @(posedge CLK or posedge Reset) begin
        if (Reset)            pc <= 32'h0;
        else if (flush)       pc <= redirect;
        else if (bus.PCWre)   pc <= pc + 32'd4;
    end

    // Memory: acks after mem_lat waiting cycles of a held request
    always @(posedge CLK or posedge Reset) begin
        if (Reset)                            mem_cnt <= 0;
        else if (!bus.imem_req || bus.imem_ack) mem_cnt <= 0;
        else                                  mem_cnt <= mem_cnt + 1;
    end

    // Expectation model: tracks whether a fetch must be issued, is on the bus,
    // is being discarded, an instruction is held, or the stage is dead.
    logic        m_issue = 1'b1, m_out = 1'b0, m_discard = 1'b0;
    logic        m_have = 1'b0, m_dead = 1'b0;
    logic [31:0] m_addr = 32'h0, m_ir = 32'h0, m_ir_pc = 32'h0, m_cnt = 32'h0;
    logic        exp_pcwre;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_issue <= 1'b1; m_out <= 1'b0; m_discard <= 1'b0;
            m_have <= 1'b0; m_dead <= 1'b0;
            m_addr <= 32'h0; m_ir <= 32'h0; m_ir_pc <= 32'h0; m_cnt <= 32'h0;
        end else if (!m_dead) begin
            if (m_issue || (m_have && !flush && ir_ready)) begin
                m_issue <= 1'b0;
                m_have  <= 1'b0;
                if (pc[1:0] != 2'b00) begin
                    m_dead <= 1'b1;
                end else begin
                    m_out <= 1'b1; m_discard <= 1'b0; m_addr <= pc;
                end
            end else if (m_out) begin
                if (bus.imem_ack) begin
                    m_out <= 1'b0;
                    if (m_discard || flush) begin
                        m_issue <= 1'b1;
                    end else begin
                        m_ir <= 32'hAAAA_0000 + m_addr;
                        m_ir_pc <= m_addr;
                        m_cnt <= m_cnt + 32'd1;
                        m_have <= 1'b1;
                    end
                end else if (flush) begin
                    m_discard <= 1'b1;
                end
            end else if (m_have && flush) begin
                m_have <= 1'b0; m_issue <= 1'b1;
            end
        end
    end

    assign exp_pcwre = m_out && !m_discard && bus.imem_ack && !flush;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus event counters
    always @(negedge CLK) begin
        chk("imem_req", {31'h0, bus.imem_req}, {31'h0, m_out});
        chk("imem_addr", bus.imem_addr, m_addr);
        chk("PCWre", {31'h0, bus.PCWre}, {31'h0, exp_pcwre});
        chk("ir_valid", {31'h0, bus.ir_valid}, {31'h0, m_have});
        chk("ir", bus.ir, m_ir);
        chk("ir_pc", bus.ir_pc, m_ir_pc);
        chk("fetch_count", bus.fetch_count, m_cnt);
        chk("align_err", {31'h0, bus.align_err}, {31'h0, m_dead});
        if (!Reset) begin
            if (bus.PCWre) begin
                pcwre_n++;
                addr_log.push_back(bus.imem_addr);
            end
            if (bus.imem_req) req_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_cnt(input logic [31:0] tgt, input int budget);
        int k;
        k = 0;
        while (bus.fetch_count !== tgt && k < budget) begin
            tick(1);
            k++;
        end
        chk("wait_fetch_count", bus.fetch_count, tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        ir_ready = 1'b1;
        tick(2);
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_count", bus.fetch_count, 32'h0);
        chk("rst_ir", bus.ir, 32'h0);
        Reset = 1'b0;
        addr_log.delete();
        pcwre_n = 0;

        // Zero-wait streaming from PC 0
        wait_cnt(32'd3, 20);
        ir_ready = 1'b0;
        chk("log_size", addr_log.size(), 32'd3);
        for (int i = 0; i < 3 && i < addr_log.size(); i++)
            chk("log_addr", addr_log[i], 32'(4 * i));
        chk("t1_pcwre_n", pcwre_n, 32'd3);
        chk("t1_ir", bus.ir, 32'hAAAA_0008);
        chk("t1_ir_pc", bus.ir_pc, 32'h8);

        // Decode stalls for 5 cycles
        req_n = 0; pcwre_n = 0;
        tick(5);
        chk("stall_ir", bus.ir, 32'hAAAA_0008);
        chk("stall_ir_pc", bus.ir_pc, 32'h8);
        chk("stall_req_n", req_n, 32'd0);
        chk("stall_pcwre_n", pcwre_n, 32'd0);

        // Ack delayed 3 cycles
        mem_lat = 3;
        ir_ready = 1'b1;
        req_n = 0; pcwre_n = 0;
        tick(1);
        ir_ready = 1'b0;
        wait_cnt(32'd4, 20);
        chk("slow_req_n", req_n, 32'd4);
        chk("slow_pcwre_n", pcwre_n, 32'd1);
        chk("slow_ir_pc", bus.ir_pc, 32'hC);
        chk("slow_ir", bus.ir, 32'hAAAA_000C);

        // Flush before ack, with a second flush pulse while draining
        ir_ready = 1'b1;
        tick(1);
        ir_ready = 1'b0;
        pcwre_n = 0;
        chk("drop_start_addr", bus.imem_addr, 32'h10);
        tick(1);
        flush = 1'b1; redirect = 32'h100;
        tick(2);
        flush = 1'b0;
        tick(1);
        chk("drop_done_req", {31'h0, bus.imem_req}, 32'h0);
        tick(1);
        chk("redirect_addr", bus.imem_addr, 32'h100);
        chk("drop_pcwre_n", pcwre_n, 32'd0);
        chk("drop_count", bus.fetch_count, 32'd4);
        wait_cnt(32'd5, 20);
        chk("redirect_ir_pc", bus.ir_pc, 32'h100);
        chk("redirect_ir", bus.ir, 32'hAAAA_0100);

        // Flush coinciding with ack
        mem_lat = 0;
        ir_ready = 1'b1;
        tick(1);
        chk("coinc_addr", bus.imem_addr, 32'h104);
        ir_ready = 1'b0; flush = 1'b1; redirect = 32'h200;
        pcwre_n = 0;
        tick(1);
        flush = 1'b0;
        chk("coinc_count", bus.fetch_count, 32'd5);
        chk("coinc_ir_pc", bus.ir_pc, 32'h100);
        tick(1);
        chk("coinc_next_addr", bus.imem_addr, 32'h200);
        tick(1);
        chk("coinc_next_count", bus.fetch_count, 32'd6);
        chk("coinc_next_ir_pc", bus.ir_pc, 32'h200);
        chk("coinc_pcwre_n", pcwre_n, 32'd1);

        // Misaligned redirect traps
        flush = 1'b1; redirect = 32'h102;
        tick(1);
        flush = 1'b0;
        tick(1);
        chk("fault_align", {31'h0, bus.align_err}, 32'h1);
        ir_ready = 1'b1;
        req_n = 0;
        tick(4);
        chk("fault_req_n", req_n, 32'd0);
        chk("fault_sticky", {31'h0, bus.align_err}, 32'h1);
        Reset = 1'b1;
        #1;
        chk("fault_cleared", {31'h0, bus.align_err}, 32'h0);
        tick(1);
        Reset = 1'b0;
        wait_cnt(32'd1, 10);
        chk("post_fault_ir_pc", bus.ir_pc, 32'h0);

        // Reset in the middle of a slow request
        mem_lat = 3;
        tick(1);
        ir_ready = 1'b0;
        chk("mid_req", {31'h0, bus.imem_req}, 32'h1);
        tick(1);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("mid_rst_count", bus.fetch_count, 32'h0);
        tick(1);
        Reset = 1'b0;
        ir_ready = 1'b1;
        wait_cnt(32'd1, 20);
        chk("mid_rst_ir_pc", bus.ir_pc, 32'h0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
